// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle restoring integer divider.
//
// Resolves one quotient bit per clock, so a nonzero-divisor operation takes
// DATAWIDTH cycles from accept to out_valid. A zero divisor takes one cycle
// and reports div_by_zero with quotient = all ones, remainder = dividend.
// Only one operation is in flight at a time.
//
// Optional feature: define SEQ_DIVIDER_SIGNED_EN to add the signed_mode input.
// With signed_mode=1, operands are two's complement. The quotient truncates
// toward zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; dividend/divisor sampled on accept
//   dividend, divisor     DATAWIDTH-bit operands
//   out_valid / out_ready result handshake; outputs held while back-pressured
//   quotient, remainder   registered DATAWIDTH-bit results
//   div_by_zero           result came from a zero divisor
//   busy                  operation in progress or result pending
//   signed_mode           (SEQ_DIVIDER_SIGNED_EN only) treat operands as signed

module seq_divider #(
    parameter int DATAWIDTH = 24,
    parameter int CNTWIDTH  = $clog2(DATAWIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] quotient,
    output logic [DATAWIDTH-1:0] remainder,
    output logic                 div_by_zero,
    output logic                 busy
`ifdef SEQ_DIVIDER_SIGNED_EN
    ,
    input  logic                 signed_mode
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [DATAWIDTH-1:0] dvd_reg;    // shifts out dividend bits, shifts in quotient bits
    logic [DATAWIDTH-1:0] dsr_reg;
    logic [DATAWIDTH-1:0] prem;       // partial remainder, always < divisor between steps
    logic [CNTWIDTH-1:0]  count;
    logic                 zero_div;

    logic [DATAWIDTH-1:0] dvd_in;
    logic [DATAWIDTH-1:0] dsr_in;
    logic [DATAWIDTH:0]   shifted;
    logic                 q_bit;
    logic [DATAWIDTH-1:0] prem_next;
    logic [DATAWIDTH-1:0] q_mag;
    logic [DATAWIDTH-1:0] q_fix;
    logic [DATAWIDTH-1:0] r_fix;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_q;
    logic neg_r;
    logic neg_q_in;
    logic neg_r_in;
`endif

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    // Operand conditioning. In signed mode the core divides magnitudes.
    // A zero divisor keeps the raw dividend, because that raw value is
    // returned as the remainder.
    always_comb begin
        dvd_in = dividend;
        dsr_in = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
        neg_q_in = 1'b0;
        neg_r_in = 1'b0;
        if (signed_mode && (divisor != '0)) begin
            neg_q_in = dividend[DATAWIDTH-1] ^ divisor[DATAWIDTH-1];
            neg_r_in = dividend[DATAWIDTH-1];
            if (dividend[DATAWIDTH-1]) dvd_in = -dividend;
            if (divisor[DATAWIDTH-1])  dsr_in = -divisor;
        end
`endif
    end

    // One restoring step. The shifted value needs DATAWIDTH+1 bits.
    // After a successful subtract the result fits back into DATAWIDTH bits,
    // so the subtraction can be done at DATAWIDTH width.
    always_comb begin
        shifted   = {prem, dvd_reg[DATAWIDTH-1]};
        q_bit     = (shifted >= {1'b0, dsr_reg});
        prem_next = q_bit ? (shifted[DATAWIDTH-1:0] - dsr_reg) : shifted[DATAWIDTH-1:0];
        q_mag     = {dvd_reg[DATAWIDTH-2:0], q_bit};
        q_fix     = q_mag;
        r_fix     = prem_next;
`ifdef SEQ_DIVIDER_SIGNED_EN
        // MIN / -1 falls out naturally: magnitude 2^(W-1) negates to itself.
        if (neg_q) q_fix = -q_mag;
        if (neg_r) r_fix = -prem_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dvd_reg     <= '0;
            dsr_reg     <= '0;
            prem        <= '0;
            count       <= '0;
            zero_div    <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        dvd_reg  <= dvd_in;
                        dsr_reg  <= dsr_in;
                        prem     <= '0;
                        zero_div <= (divisor == '0);
                        // A zero divisor spends a single CALC cycle so its
                        // result appears one edge after accept.
                        count    <= (divisor == '0) ? CNTWIDTH'(1) : CNTWIDTH'(DATAWIDTH);
                        state    <= S_CALC;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_q    <= neg_q_in;
                        neg_r    <= neg_r_in;
`endif
                    end
                end
                S_CALC: begin
                    if (zero_div) begin
                        quotient    <= '1;
                        remainder   <= dvd_reg;
                        div_by_zero <= 1'b1;
                        count       <= '0;
                        state       <= S_DONE;
                    end else begin
                        prem    <= prem_next;
                        dvd_reg <= q_mag;
                        count   <= count - CNTWIDTH'(1);
                        if (count == CNTWIDTH'(1)) begin
                            quotient    <= q_fix;
                            remainder   <= r_fix;
                            div_by_zero <= 1'b0;
                            state       <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- self-checking bench for seq_divider (DATAWIDTH=24).
// It combines a constant vector table, hand-written corner sequences
// (back-pressure, mid-operation reset) and randomized operations.
// Random operations are checked against a plain-arithmetic reference model.

module tb_seq_divider;

    localparam int W = 24;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         busy;
    logic         signed_mode;

    int checks   = 0;
    int failures = 0;

    seq_divider #(.DATAWIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .busy        (busy)
`ifdef SEQ_DIVIDER_SIGNED_EN
        ,
        .signed_mode (signed_mode)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dsr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Unsigned reference: plain division, zero divisor handled as a special case.
    task automatic refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [W-1:0] q, output logic [W-1:0] r,
                            output logic dbz);
        if (b == 0) begin
            q = '1; r = a; dbz = 1'b1;
        end else begin
            q = a / b; r = a % b; dbz = 1'b0;
        end
    endtask

    // Waits for in_ready, presents operands, returns at the negedge after accept.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sm);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        checkOutput("in_ready_wait", 32'(w < 50), 32'd1);
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        dividend    = 24'h5A5A5A;
        divisor     = 24'h000003;
    endtask

    // Counts edges until out_valid (bounded); a timeout yields a large count.
    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sm, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input int elat);
        int lat;
        applyStimulus(a, b, sm);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
        waitResult(lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'(elat));
        checkOutput({tag, "_quotient"}, 32'(quotient), 32'(eq));
        checkOutput({tag, "_remainder"}, 32'(remainder), 32'(er));
        checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
        @(negedge clk);
    endtask

    initial begin
        int           lat;
        logic [W-1:0] a, b, eq, er;
        logic         edbz;

        vecs[0] = '{24'd100,     24'd7,        24'd14,       24'd2,    1'b0, 24};
        vecs[1] = '{24'hFFFFFF,  24'd1,        24'hFFFFFF,   24'd0,    1'b0, 24};
        vecs[2] = '{24'd5,       24'd9,        24'd0,        24'd5,    1'b0, 24};
        vecs[3] = '{24'd1234,    24'd0,        24'hFFFFFF,   24'd1234, 1'b1, 1};
        vecs[4] = '{24'd0,       24'd5,        24'd0,        24'd0,    1'b0, 24};
        vecs[5] = '{24'hFFFFFF,  24'hFFFFFF,   24'd1,        24'd0,    1'b0, 24};
        vecs[6] = '{24'd23,      24'hFFFFFF,   24'd0,        24'd23,   1'b0, 24};
        vecs[7] = '{24'hABCDEF,  24'h000010,   24'h0ABCDE,   24'hF,    1'b0, 24};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        dividend    = '0;
        divisor     = '0;
        signed_mode = 1'b0;

        #12;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_quotient", 32'(quotient), 32'd0);
        checkOutput("rst_remainder", 32'(remainder), 32'd0);
        checkOutput("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            runOp($sformatf("vec%0d", i), vecs[i].dvd, vecs[i].dsr, 1'b0,
                  vecs[i].q, vecs[i].r, vecs[i].dbz, vecs[i].lat);
        end

        // Back-pressure hold, with an in_valid pulse during CALC that must be ignored.
        out_ready = 1'b0;
        applyStimulus(24'd1000, 24'd10, 1'b0);
        repeat (3) @(negedge clk);
        in_valid = 1'b1;
        dividend = 24'd77;
        divisor  = 24'd3;
        @(negedge clk);
        in_valid = 1'b0;
        waitResult(lat);
        checkOutput("bp_seen", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("bp_hold%0d_q", k), 32'(quotient), 32'd100);
            checkOutput($sformatf("bp_hold%0d_r", k), 32'(remainder), 32'd0);
            checkOutput($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_valid", 32'(out_valid), 32'd0);
        checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp_keep_quotient", 32'(quotient), 32'd100);
        @(negedge clk);
        checkOutput("bp_no_spurious_op", 32'(busy), 32'd0);

        // Reset in the middle of CALC aborts without producing a result.
        applyStimulus(24'd500, 24'd3, 1'b0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_quotient", 32'(quotient), 32'd0);
        checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        runOp("post_reset", 24'd9, 24'd4, 1'b0, 24'd2, 24'd1, 1'b0, 24);

        // Randomized operations against the reference model.
        for (int n = 0; n < 20; n++) begin
            a = 24'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 24'd0;
                1:       b = 24'($urandom_range(1, 15));
                2:       b = 24'($urandom_range(1, 4095));
                default: b = 24'($urandom);
            endcase
            refModel(a, b, eq, er, edbz);
            runOp($sformatf("rand%0d", n), a, b, 1'b0, eq, er, edbz, (b == 0) ? 1 : 24);
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        runOp("s_neg7_2", 24'hFFFFF9, 24'd2, 1'b1, 24'hFFFFFD, 24'hFFFFFF, 1'b0, 24);
        runOp("s_7_neg2", 24'd7, 24'hFFFFFE, 1'b1, 24'hFFFFFD, 24'd1, 1'b0, 24);
        runOp("s_min_neg1", 24'h800000, 24'hFFFFFF, 1'b1, 24'h800000, 24'd0, 1'b0, 24);
        runOp("s_div0", 24'hFFFFF0, 24'd0, 1'b1, 24'hFFFFFF, 24'hFFFFF0, 1'b1, 1);
        runOp("s_unsigned_mode", 24'hFFFFF9, 24'd2, 1'b0, 24'h7FFFFC, 24'd1, 1'b0, 24);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring integer divider with valid/ready handshakes on input and output.
- Produces quotient, remainder and a divide-by-zero flag. Resolves one quotient bit per clock.
- Parametrised successor to the team's combinational divider, for datapaths where a full-width combinational divide would not close timing.
- Sits between an upstream producer and a downstream consumer.
- Processes one operation at a time. No pipelining.

Parameters:
- DATAWIDTH, 24, width of dividend, divisor, quotient and remainder (legal range 2..64).
- CNTWIDTH, $clog2(DATAWIDTH+1), width of the internal bit counter. Derived; not to be overridden.

Ports:
- clk  input  1  Single clock; all flops rising-edge.
- rst_n  input  1  Reset, asynchronous and active-low.
- in_valid  input  1  Operands on dividend/divisor are valid.
- in_ready  output  1  Block can accept an operation.
- dividend  input  DATAWIDTH  Dividend, sampled on the accept edge.
- divisor  input  DATAWIDTH  Divisor, sampled on the accept edge.
- out_valid  output  1  Result outputs are valid.
- out_ready  input  1  Consumer accepts the result.
- quotient  output  DATAWIDTH  Registered quotient.
- remainder  output  DATAWIDTH  Registered remainder.
- div_by_zero  output  1  Result came from a zero divisor.
- busy  output  1  High in CALC and DONE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - State goes to IDLE.
  - quotient, remainder and the counter clear to 0.
  - out_valid=0, div_by_zero=0, busy=0, in_ready=1 (combinational from IDLE).
- Reset mid-operation aborts the operation with no output. After reset release the block accepts a new operation immediately.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - Accept = in_valid && in_ready at a rising edge (edge 0).
  - On accept: capture operands into internal registers. Later changes on the input ports do not affect the operation.
  - If divisor != 0: clear the partial remainder, load the counter with DATAWIDTH, go to CALC.
  - If divisor == 0: go to DONE at edge 1 with quotient = all ones, remainder = captured dividend, div_by_zero=1.
- CALC:
  - in_ready=0.
  - Each edge: shift {partial remainder, dividend register} left by 1 (partial remainder width DATAWIDTH+1).
  - If partial remainder >= divisor: subtract and set the new LSB of the quotient to 1; else set it to 0.
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: load quotient/remainder outputs (including sign fix-up when the optional feature is enabled), set div_by_zero=0, go to DONE.
- Latency: out_valid rises DATAWIDTH edges after the accept edge for a nonzero divisor, and 1 edge after for a zero divisor.
- DONE:
  - out_valid=1. Outputs are held stable while out_valid && !out_ready; this is a back-pressure hold of unlimited duration.
  - Edge with out_ready=1: out_valid=0, go to IDLE. in_ready is not asserted in the same cycle, so there is one bubble cycle between operations.
- in_valid while busy is ignored. The producer must hold its operands until in_ready.
- out_ready outside DONE is ignored.
- Unsigned arithmetic:
  - Result satisfies dividend = quotient*divisor + remainder, with remainder < divisor.
  - Quotient of DATAWIDTH-bit operands never overflows.
- quotient and remainder keep their last values after the handshake; they are only meaningful while out_valid=1.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled with the operands.
  - When signed_mode=1, operands are two's complement. The divider works on magnitudes.
  - Quotient is negated when operand signs differ (truncation toward zero). Remainder takes the dividend's sign.
  - MIN/-1 gives quotient=MIN and remainder=0, with no flag.
  - Divide by zero in signed mode gives quotient = all ones, remainder = dividend, div_by_zero=1.
  - Latency is unchanged; sign fix-up happens on the final CALC edge.
- Not defined: port absent, unsigned-only behaviour, no extra logic.

Test Plan:
- DATAWIDTH=24, dividend=100, divisor=7, out_ready=1 -> out_valid exactly 24 cycles after accept; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFF, divisor=1; then dividend=5, divisor=9 -> quotient=0xFFFFFF, remainder=0; then quotient=0, remainder=5.
- dividend=1234, divisor=0 -> out_valid 1 cycle after accept; quotient=0xFFFFFF, remainder=1234, div_by_zero=1.
- dividend=1000, divisor=10, out_ready held 0 for 5 cycles after out_valid -> outputs stable at quotient=100, remainder=0, in_ready=0 throughout. One cycle after out_ready=1, in_ready=1. in_valid pulsed during CALC has no effect.
- Accept 500/3, assert rst_n=0 at cycle 10 of CALC -> out_valid=0, quotient=0, in_ready=1 immediately. A post-reset 9/4 gives quotient=2, remainder=1.
- With SEQ_DIVIDER_SIGNED_EN and signed_mode=1:
  - -7/2 -> quotient=-3 (0xFFFFFD), remainder=-1 (0xFFFFFF).
  - 7/-2 -> quotient=-3, remainder=1.
  - 0x800000/0xFFFFFF -> quotient=0x800000, remainder=0.
